neural_stage_buffer: RTL

- Inter-layer ping-pong buffer directly downstream of a neural stage.
- Captures the serialized per-neuron result vector (N words, one per cycle) shifted out after the stage's sigmoid.
- Replays the vector as the input data stream for the next neural stage, with a one-cycle `out_first` pulse on element 0 that drives that stage's `first` input.
- Two banks, so one vector can be captured while the previous one is replayed.

---
 rtl/neural_stage_buffer_pkg.sv | 15 +
 rtl/neural_stage_buffer_bank.sv | 48 ++++
 rtl/neural_stage_buffer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/neural_stage_buffer_pkg.sv
// Shared types for the inter-layer ping-pong buffer.
// Word format and vector length of the upstream neural stage.
package neural_stage_buffer_pkg;

  typedef logic [31:0] float_24_8;

  localparam int NEURONS = 16;

  typedef logic bank_idx_t;

  function automatic bank_idx_t other_bank(input bank_idx_t b);
    return ~b;
  endfunction

endpackage

// File: rtl/neural_stage_buffer_bank.sv
// One bank of the ping-pong buffer: N-deep register file,
// indexed write, registered read index.
module neural_stage_buffer_bank
  import neural_stage_buffer_pkg::*;
#(
  parameter  int DATA_W = $bits(float_24_8),
  parameter  int N      = NEURONS,
  localparam int IDX_W  = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  w_idx,
  input  logic [DATA_W-1:0] w_data,
  input  logic [IDX_W-1:0]  r_idx,
  output logic [DATA_W-1:0] r_data
);

  logic [DATA_W-1:0] mem_q [N];
  logic [DATA_W-1:0] mem_d [N];
  logic [IDX_W-1:0]  r_idx_q;
  logic [IDX_W-1:0]  r_idx_d;

  // Next array contents: at most one word replaced per cycle.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[w_idx] = w_data;
  end

  // Read address is captured; data follows one cycle later.
  always_comb begin
    r_idx_d = r_idx;
  end

  // Word storage carries no reset; a bank is only read once full.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Registered read index.
  always_ff @(posedge clk) begin
    if (reset) r_idx_q <= '0;
    else       r_idx_q <= r_idx_d;
  end

  assign r_data = mem_q[r_idx_q];

endmodule

// File: rtl/neural_stage_buffer.sv
// Ping-pong buffer between two neural stages: captures one
// N-word vector per bank and replays it as a gap-free burst.
module neural_stage_buffer
  import neural_stage_buffer_pkg::*;
#(
  parameter  int DATA_W = $bits(float_24_8),
  parameter  int N      = NEURONS,
  localparam int IDX_W  = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              out_first,
  output logic              out_last,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        bank_full,
  output logic              overflow,
  output logic              truncated,
  input  logic              clear_err
);

  localparam logic WR_IDLE  = 1'b0;
  localparam logic WR_WRITE = 1'b1;
  localparam logic RD_IDLE  = 1'b0;
  localparam logic RD_READ  = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic             wr_state_q, wr_state_d;
  bank_idx_t        wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;

  logic             rd_state_q, rd_state_d;
  bank_idx_t        rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             clr_pend_q, clr_pend_d;
  bank_idx_t        clr_bank_q, clr_bank_d;

  logic [1:0]       bank_full_q, bank_full_d;
  logic             overflow_q, overflow_d;
  logic             truncated_q, truncated_d;

  logic              out_valid_q, out_valid_d;
  logic              out_first_q, out_first_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              bank_free;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_addr;
  logic              wr_done;
  logic              ovf_set;
  logic              trunc_set;
  logic [IDX_W-1:0]  rd_addr;
  logic [1:0]        bank_we;
  logic [DATA_W-1:0] rd_data [2];

  // Write side: accept, restart or drop incoming vectors.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_bank_d  = wr_bank_q;
    wr_idx_d   = wr_idx_q;
    wr_en      = 1'b0;
    wr_addr    = wr_idx_q;
    wr_done    = 1'b0;
    ovf_set    = 1'b0;
    trunc_set  = 1'b0;
    bank_free  = !bank_full_q[wr_bank_q] &&
                 !(rd_state_q == RD_READ &&
                   rd_bank_q == wr_bank_q);
    if (in_valid) begin
      unique case (1'b1)
        in_start && wr_state_q == WR_WRITE: begin
          trunc_set = 1'b1;
          wr_en     = 1'b1;
          wr_addr   = '0;
        end
        in_start && wr_state_q == WR_IDLE && bank_free: begin
          wr_en   = 1'b1;
          wr_addr = '0;
        end
        in_start && wr_state_q == WR_IDLE && !bank_free: begin
          ovf_set = 1'b1;
        end
        !in_start && wr_state_q == WR_WRITE: begin
          wr_en = 1'b1;
        end
        default: ;
      endcase
    end
    if (wr_en) begin
      wr_state_d = WR_WRITE;
      wr_idx_d   = wr_addr + IDX_W'(1);
      if (wr_addr == LAST_IDX) begin
        wr_done    = 1'b1;
        wr_state_d = WR_IDLE;
        wr_idx_d   = '0;
        wr_bank_d  = other_bank(wr_bank_q);
      end
    end
  end

  assign bank_we[0] = wr_en & (wr_bank_q == 1'b0);
  assign bank_we[1] = wr_en & (wr_bank_q == 1'b1);

  // Read side: launch a burst, then stream one word per cycle.
  // The bank is released one cycle after its last word leaves.
  always_comb begin
    rd_state_d  = rd_state_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    clr_pend_d  = 1'b0;
    clr_bank_d  = clr_bank_q;
    rd_addr     = '0;
    out_valid_d = 1'b0;
    out_first_d = 1'b0;
    out_last_d  = 1'b0;
    out_data_d  = '0;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (bank_full_q[rd_bank_q] && out_ready) begin
          rd_state_d = RD_READ;
          rd_cnt_d   = '0;
        end
      end
      RD_READ: begin
        out_valid_d = 1'b1;
        out_first_d = (rd_cnt_q == '0);
        out_last_d  = (rd_cnt_q == LAST_IDX);
        out_data_d  = rd_data[rd_bank_q];
        rd_addr     = rd_cnt_q + IDX_W'(1);
        rd_cnt_d    = rd_cnt_q + IDX_W'(1);
        if (rd_cnt_q == LAST_IDX) begin
          rd_state_d = RD_IDLE;
          rd_bank_d  = other_bank(rd_bank_q);
          rd_cnt_d   = '0;
          clr_pend_d = 1'b1;
          clr_bank_d = rd_bank_q;
        end
      end
      default: ;
    endcase
  end

  // Bank occupancy and sticky error flags.
  always_comb begin
    bank_full_d = bank_full_q;
    if (clr_pend_q) bank_full_d[clr_bank_q] = 1'b0;
    if (wr_done)    bank_full_d[wr_bank_q]  = 1'b1;
    overflow_d  = clear_err ? 1'b0 : (overflow_q | ovf_set);
    truncated_d = clear_err ? 1'b0 : (truncated_q | trunc_set);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_q  <= WR_IDLE;
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_state_q  <= RD_IDLE;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      clr_pend_q  <= 1'b0;
      clr_bank_q  <= 1'b0;
      bank_full_q <= '0;
      overflow_q  <= 1'b0;
      truncated_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_state_q  <= wr_state_d;
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_state_q  <= rd_state_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      clr_pend_q  <= clr_pend_d;
      clr_bank_q  <= clr_bank_d;
      bank_full_q <= bank_full_d;
      overflow_q  <= overflow_d;
      truncated_q <= truncated_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  neural_stage_buffer_bank #(
    .DATA_W(DATA_W),
    .N     (N)
  ) u_bank0 (
    .clk   (clk),
    .reset (reset),
    .we    (bank_we[0]),
    .w_idx (wr_addr),
    .w_data(in_data),
    .r_idx (rd_addr),
    .r_data(rd_data[0])
  );

  neural_stage_buffer_bank #(
    .DATA_W(DATA_W),
    .N     (N)
  ) u_bank1 (
    .clk   (clk),
    .reset (reset),
    .we    (bank_we[1]),
    .w_idx (wr_addr),
    .w_data(in_data),
    .r_idx (rd_addr),
    .r_data(rd_data[1])
  );

  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign bank_full = bank_full_q;
  assign overflow  = overflow_q;
  assign truncated = truncated_q;

endmodule
